// File: rtl/flag_branch_unit.sv
// Flag register and conditional-branch resolver.
// Holds the architectural {N,V,Z} flags, evaluates B/BR conditions against
// forwarded flags, returns a registered one-cycle redirect and counts taken
// branches with saturation.
module flag_branch_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_wr,
  input  logic             N_in,
  input  logic             V_in,
  input  logic             Z_in,
  input  logic             N_en,
  input  logic             V_en,
  input  logic             Z_en,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic             br_reg,
  input  logic [2:0]       ccc,
  input  logic [8:0]       imm,
  input  logic [15:0]      pc_plus2,
  input  logic [15:0]      rs_val,
  output logic             resolved,
  output logic             taken,
  output logic [15:0]      redirect_pc,
  output logic [2:0]       flags,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RESOLVE,
    FLUSH
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        n_eff;
  logic        v_eff;
  logic        z_eff;
  logic        cond;
  logic        accept;
  logic [15:0] target;
  logic [15:0] next_pc;

  // Effective flags: a same-cycle enabled write bypasses the register
  always_comb begin
    n_eff = (flag_wr && N_en) ? N_in : flags[2];
    v_eff = (flag_wr && V_en) ? V_in : flags[1];
    z_eff = (flag_wr && Z_en) ? Z_in : flags[0];
  end

  // Condition-code evaluation
  always_comb begin
    cond = 1'b0;
    unique case (ccc)
      3'b000: cond = !z_eff;
      3'b001: cond = z_eff;
      3'b010: cond = !z_eff && !n_eff;
      3'b011: cond = n_eff;
      3'b100: cond = z_eff || !n_eff;
      3'b101: cond = n_eff || z_eff;
      3'b110: cond = v_eff;
      3'b111: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  // Branch target and next PC (B offset is a signed word count)
  always_comb begin
    target  = br_reg ? rs_val : (pc_plus2 + {{6{imm[8]}}, imm, 1'b0});
    next_pc = cond ? target : pc_plus2;
  end

  // Next-state and handshake; a taken resolution blocks RESOLVE and FLUSH
  always_comb begin
    state_nxt = state;
    br_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        br_ready = 1'b1;
        if (br_valid) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        if (taken) begin
          state_nxt = FLUSH;
        end else begin
          br_ready  = 1'b1;
          state_nxt = br_valid ? RESOLVE : IDLE;
        end
      end
      FLUSH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) br_ready = 1'b0;
    accept = br_valid && br_ready;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Flag register with per-flag enables gated by flag_wr
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (flag_wr) begin
      if (N_en) flags[2] <= N_in;
      if (V_en) flags[1] <= V_in;
      if (Z_en) flags[0] <= Z_in;
    end
  end

  // Registered resolution outputs; taken/redirect_pc hold between pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resolved    <= 1'b0;
      taken       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      resolved <= accept;
      if (accept) begin
        taken       <= cond;
        redirect_pc <= next_pc;
      end
    end
  end

  // Saturating taken-branch counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_cnt <= '0;
    end else if (resolved && taken && (taken_cnt != '1)) begin
      taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Flag-consuming end of the ALU's N/V/Z interface. Holds the architectural N, V and Z flag register, updated from the ALU's per-flag enables. Resolves conditional B/BR branches against those flags, forwarding same-cycle flag writes. Returns a registered one-cycle redirect to fetch and keeps a saturating count of taken branches.

## Interface
Parameters:
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- flag_wr  in  1  the ALU instruction in EX commits this cycle; gates all flag writes.
- N_in, V_in, Z_in  in  1 each  flag values from the ALU.
- N_en, V_en, Z_en  in  1 each  per-flag write enables from the ALU.
- br_valid  in  1  branch presented for resolution.
- br_ready  out  1  the unit accepts the branch this cycle.
- br_reg  in  1  1 = BR (target is rs_val); 0 = B (PC-relative target).
- ccc  in  3  condition code.
- imm  in  9  signed word offset for B.
- pc_plus2  in  16  address of the instruction after the branch.
- rs_val  in  16  register target for BR.
- resolved  out  1  one-cycle pulse; the branch accepted last cycle is resolved.
- taken  out  1  condition result; valid when resolved=1.
- redirect_pc  out  16  next PC; valid when resolved=1.
- flags  out  3  {N,V,Z} register contents.
- taken_cnt  out  CNT_W  number of taken branches, saturating.

## Operation
- **Flag register.** At each edge with flag_wr=1, every flag whose enable is 1 loads its _in value. Flags whose enable is 0 hold. With flag_wr=0, no flag changes.
- **Effective flags for evaluation.** For each flag: if flag_wr and that flag's enable are both 1, the flag's _in value is used (forwarding). Otherwise the register value is used.
- **Condition codes** (on the effective flags):
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GE: Z=1, or Z=0 and N=0
  - 101 LE: N=1 or Z=1
  - 110 OV: V=1
  - 111 always taken
- **Target.**
  - B: pc_plus2 + (sign_extend(imm) << 1), computed modulo 2^16.
  - BR: rs_val.
  - redirect_pc = target when taken, otherwise pc_plus2.
- **States.**
  - IDLE: br_ready=1.
  - RESOLVE: outputs of the accepted branch are presented.
  - FLUSH: one bubble after a taken branch.
- **Transitions.**
  - IDLE: on accept (br_valid & br_ready), go to RESOLVE; otherwise stay in IDLE.
  - RESOLVE, not taken: br_ready=1. A new accept stays in RESOLVE (back-to-back branches); no accept goes to IDLE.
  - RESOLVE, taken: br_ready=0 (the instruction presented this cycle is wrong-path) and the next state is FLUSH.
  - FLUSH: br_ready=0, br_valid is ignored, and the next state is IDLE.
- **Counter.** taken_cnt increments on each resolved&taken pulse. It holds at 2^CNT_W−1 and never wraps.
- **Don't-care inputs.** br_reg, ccc, imm, pc_plus2 and rs_val are sampled only at accept; at all other times they are don't-care.

## Timing
- **Reset** (rst_n low at an edge):
  - flags=000, state=IDLE
  - resolved=0, taken=0, redirect_pc=16'h0000
  - taken_cnt=0
  - br_ready is 0 while rst_n is low.
- **Reset mid-operation.** A pending RESOLVE or FLUSH is discarded, and no resolved pulse follows.
- **Accept-to-resolve latency.** The branch is accepted at edge k. resolved, taken and redirect_pc are registered and valid for exactly the cycle after edge k; resolved falls at edge k+1 unless another branch is accepted.
- **Condition evaluation.** Evaluated in the accept cycle, using the effective flags of that cycle.
- **Simultaneous flag write and accept.** The branch sees the new value of each enabled flag and the old value of each disabled flag. The register update and the branch capture happen at the same edge.
- **Taken branch.** br_ready is low for 2 cycles after the taken resolution begins: the RESOLVE cycle and the FLUSH cycle.
- **Not-taken branches.** Sustain one accept per cycle.
- **Flag updates in RESOLVE and FLUSH.** Flag writes proceed normally in these states; they are independent of the branch state.

## Test plan
- **Reset.** Hold rst_n=0 for 2 cycles with br_valid=1 → flags=000, resolved=0, redirect_pc=0000, taken_cnt=0, br_ready=0; after release, br_ready=1.
- **Forwarding.**
  - Flags start at Z=0.
  - In the same cycle drive flag_wr=1, Z_en=1, Z_in=1, and accept B with ccc=001, imm=9'h1FE, pc_plus2=16'h0100.
  - Required: next cycle resolved=1, taken=1, redirect_pc=16'h00FC, and flags then read Z=1.
- **Taken BR and flush.** Accept BR with ccc=111, rs_val=16'hBEEF, and hold br_valid=1 → resolved with redirect_pc=BEEF; br_ready=0 for the next 2 cycles; the next accept occurs 3 cycles after the first; taken_cnt=1.
- **Not-taken back-to-back.**
  - With N=0, accept LT branches (ccc=011) in three consecutive cycles at pc_plus2=0x10, 0x12, 0x14.
  - Required: three consecutive resolved pulses with taken=0 and redirect_pc=0x10, 0x12, 0x14; br_ready stays 1.
- **Per-flag enables.** Drive flag_wr=1, N_en=1, V_en=0, Z_en=0 with N_in=V_in=Z_in=1 → flags=100. Then flag_wr=0 with all enables=1 → flags unchanged.
- **Counter saturation and wrap.**
  - With CNT_W=2, perform 5 taken branches → taken_cnt=3.
  - B with imm=9'h0FF and pc_plus2=16'hFF00 → redirect_pc=16'h00FE (wraps).
